// File: rtl/data_mem.sv
// Clocked, byte-writable data memory with a request handshake, a read pipeline of
// RD_LAT stages, self-clearing after reset, and out-of-range address flagging.
module data_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     ADDR,
   input  logic [DATA_W-1:0]     DIN,
   input  logic [DATA_W/8-1:0]   BE,
   input  logic                  en_W,
   input  logic                  en_R,
   output logic [DATA_W-1:0]     R,
   output logic                  R_valid,
   output logic                  err,
   output logic                  busy
);

   localparam int NB = DATA_W / 8;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Compare width wide enough that neither ADDR nor DEPTH is ever truncated.
   localparam int CW = (ADDR_W > 32) ? ADDR_W + 1 : 33;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [AW-1:0]     clr_idx;
   logic              clr_last;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [CW-1:0]     addr_ext;
   logic [AW-1:0]     idx;
   logic              in_range;
   logic              accept;
   logic              do_wr;
   logic              do_rd;
   logic              oor_hit;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] rd_word;

   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_e;
   logic [DATA_W-1:0] pipe_d [RD_LAT];

   // ------------------------------------------------------------------
   // Control FSM: INIT sweeps the array to zero, READY serves requests.
   // ------------------------------------------------------------------
   always_comb clr_last = (clr_idx == AW'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_INIT: begin
            busy = 1'b1;
            if (clr_last) state_d = ST_READY;
         end
         ST_READY: begin
            req_ready = 1'b1;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_idx <= '0;
      end else if (state_q == ST_INIT) begin
         clr_idx <= clr_last ? '0 : clr_idx + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Request decode and byte merge.
   // ------------------------------------------------------------------
   always_comb begin
      addr_ext = CW'(ADDR);
      in_range = (addr_ext < CW'(DEPTH));
      idx      = addr_ext[AW-1:0];
      accept   = req_valid && req_ready;
      do_wr    = accept && en_W && in_range;
      do_rd    = accept && en_R;
      oor_hit  = accept && !in_range && (en_W || en_R);
   end

   // NOTE: combinational blocks use blocking assignments with a default first,
   // so every bit of merged is driven on every path and no latch is inferred.
   always_comb begin
      cur_word = mem[idx];
      merged   = cur_word;
      for (int b = 0; b < NB; b++) begin
         if (BE[b]) merged[8*b +: 8] = DIN[8*b +: 8];
      end
      // A combined write+read returns the post-write word.
      if (!in_range)  rd_word = '0;
      else if (en_W)  rd_word = merged;
      else            rd_word = cur_word;
   end

   // NOTE: the array has no reset branch so it maps onto RAM; the INIT sweep is
   // what clears it after every reset.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem[clr_idx] <= '0;
      end else if (do_wr) begin
         mem[idx] <= merged;
      end
   end

   // ------------------------------------------------------------------
   // Read pipeline. Data stages only load when a valid read passes, so the
   // last stage holds the previous result while R_valid is low.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         pipe_e <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_d[i] <= '0;
      end else begin
         pipe_v[0] <= do_rd;
         pipe_e[0] <= oor_hit;
         if (do_rd) pipe_d[0] <= rd_word;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   assign R       = pipe_d[RD_LAT-1];
   assign R_valid = pipe_v[RD_LAT-1];
   assign err     = pipe_e[RD_LAT-1];

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: runs RD_LAT=1 and RD_LAT=2 instances side by side
// against a timeline model, plus a directed vector table and reset sequences.
module tb_data_mem;

   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid = 1'b0;
   logic        en_w = 1'b0;
   logic        en_r = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] din = '0;
   logic [3:0]  be = '0;

   logic        rdy1, rdy2, busy1, busy2, rv1, rv2, err1, err2;
   logic [31:0] r1, r2;

   always #5 clk = ~clk;

   data_mem #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
      .ADDR(addr), .DIN(din), .BE(be), .en_W(en_w), .en_R(en_r),
      .R(r1), .R_valid(rv1), .err(err1), .busy(busy1)
   );

   data_mem #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
      .ADDR(addr), .DIN(din), .BE(be), .en_W(en_w), .en_R(en_r),
      .R(r2), .R_valid(rv2), .err(err2), .busy(busy2)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Outcome of one clock edge: what a read (or out-of-range write) produces.
   typedef struct packed {
      logic        v;
      logic        e;
      logic [31:0] d;
   } ev_t;

   ev_t         hist[$];
   logic [31:0] mem_m [DEPTH];
   int          init_cnt = 0;
   logic [31:0] exp_r1 = '0;
   logic [31:0] exp_r2 = '0;
   int          pulses1 = 0;
   int          pulses2 = 0;

   typedef struct packed {
      logic        rv;
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic        xv;
      logic        xe;
      logic [31:0] xr;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory semantics at the level of whole words and bytes, one edge at a time.
   task automatic model_edge();
      ev_t        ev;
      logic       oor;
      logic [4:0] ix;
      ev = '0;
      if (req_valid && init_cnt == DEPTH) begin
         oor = (addr >= 32'(DEPTH));
         ix  = addr[4:0];
         if (en_w && !oor) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) mem_m[ix][8*b +: 8] = din[8*b +: 8];
         end
         if (en_r) begin
            ev.v = 1'b1;
            ev.e = oor;
            ev.d = oor ? 32'h0 : mem_m[ix];
         end else if (en_w && oor) begin
            ev.e = 1'b1;
         end
      end else if (init_cnt < DEPTH) begin
         init_cnt++;
      end
      hist.push_back(ev);
      if (hist.size() > 4) void'(hist.pop_front());
   endtask

   // An edge's outcome is visible RD_LAT-1 edges later.
   task automatic compare_all();
      ev_t  e1, e2;
      logic rdy_m;
      e1 = (hist.size() >= 1) ? hist[hist.size()-1] : '0;
      e2 = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      if (e1.v) exp_r1 = e1.d;
      if (e2.v) exp_r2 = e2.d;
      rdy_m = rst_n && (init_cnt == DEPTH);
      check("lat1 req_ready", 32'(rdy1),  32'(rdy_m));
      check("lat1 busy",      32'(busy1), 32'(!rdy_m));
      check("lat1 R_valid",   32'(rv1),   32'(e1.v));
      check("lat1 err",       32'(err1),  32'(e1.e));
      check("lat1 R",         r1,         exp_r1);
      check("lat2 req_ready", 32'(rdy2),  32'(rdy_m));
      check("lat2 busy",      32'(busy2), 32'(!rdy_m));
      check("lat2 R_valid",   32'(rv2),   32'(e2.v));
      check("lat2 err",       32'(err2),  32'(e2.e));
      check("lat2 R",         r2,         exp_r2);
      if (rv1) pulses1++;
      if (rv2) pulses2++;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      hist.delete();
      init_cnt = 0;
      exp_r1   = '0;
      exp_r2   = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      #1;
      compare_all();
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input logic v, input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req_valid = v;
      en_w      = w;
      en_r      = r;
      addr      = a;
      din       = d;
      be        = b;
   endtask

   task automatic read_all();
      pulses1 = 0;
      pulses2 = 0;
      for (int a = 0; a < DEPTH; a++) begin
         set_req(1'b1, 1'b0, 1'b1, 32'(a), 32'h0, 4'h0);
         step();
      end
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) step();
      check("read-all lat1 pulses", 32'(pulses1), 32'(DEPTH));
      check("read-all lat2 pulses", 32'(pulses2), 32'(DEPTH));
   endtask

   initial begin
      //          rv    w     r     addr          din           be    xv    xe    xr
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd5,        32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 32'h00000000};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd5,        32'h11223344, 4'h5, 1'b0, 1'b0, 32'h00000000};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'd5,        32'h0,        4'h0, 1'b1, 1'b0, 32'hAA22CC44};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'd7,        32'h12345678, 4'hF, 1'b0, 1'b0, 32'hAA22CC44};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'd7,        32'h0,        4'h0, 1'b1, 1'b0, 32'h12345678};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'd3,        32'hDEADBEEF, 4'h3, 1'b1, 1'b0, 32'h0000BEEF};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'd0,        32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h0000BEEF};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'd32,       32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0000BEEF};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd32,       32'h0,        4'h0, 1'b1, 1'b1, 32'h00000000};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd0,        32'h0,        4'h0, 1'b1, 1'b0, 32'hCAFEF00D};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 32'd0,        32'h0,        4'h0, 1'b0, 1'b0, 32'hCAFEF00D};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 32'd0,        32'h0,        4'h0, 1'b0, 1'b0, 32'hCAFEF00D};
      vecs[12] = '{1'b1, 1'b0, 1'b1, 32'd0,        32'h0,        4'h0, 1'b1, 1'b0, 32'hCAFEF00D};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h80000000, 32'h0,        4'h0, 1'b1, 1'b1, 32'h00000000};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 32'd0,        32'h0,        4'h0, 1'b0, 1'b0, 32'h00000000};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 32'd31,       32'h0,        4'h0, 1'b1, 1'b0, 32'h00000000};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 32'd31,       32'h01020304, 4'hF, 1'b0, 1'b0, 32'h00000000};
      vecs[17] = '{1'b1, 1'b0, 1'b1, 32'd31,       32'h0,        4'h0, 1'b1, 1'b0, 32'h01020304};

      rst_n = 1'b1;
      #2;

      // Reset and INIT sweep, with a request held pending that must be ignored.
      apply_reset();
      set_req(1'b1, 1'b1, 1'b1, 32'd1, 32'hFFFFFFFF, 4'hF);
      repeat (DEPTH) step();
      check("ready after INIT", 32'(rdy1 & rdy2), 32'h1);
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      read_all();

      // Directed vectors; the table holds RD_LAT=1 results, the model covers both.
      for (int i = 0; i < 18; i++) begin
         set_req(vecs[i].rv, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].b);
         step();
         check($sformatf("vec%0d R_valid", i), 32'(rv1),  32'(vecs[i].xv));
         check($sformatf("vec%0d err", i),     32'(err1), 32'(vecs[i].xe));
         check($sformatf("vec%0d R", i),       r1,        vecs[i].xr);
      end
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) step();

      // Randomized traffic, biased towards a few addresses to provoke hazards.
      repeat (400) begin
         req_valid = ($urandom_range(0, 9) != 0);
         en_w      = 1'($urandom_range(0, 1));
         en_r      = 1'($urandom_range(0, 1));
         be        = 4'($urandom);
         din       = $urandom;
         case ($urandom_range(0, 9))
            0:       addr = $urandom;
            1:       addr = 32'(DEPTH) + 32'($urandom_range(0, 3));
            2, 3, 4: addr = 32'($urandom_range(0, 3));
            default: addr = 32'($urandom_range(0, DEPTH - 1));
         endcase
         step();
      end
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) step();

      // Seed known data, then reset in the middle of four back-to-back reads.
      set_req(1'b1, 1'b1, 1'b0, 32'd2, 32'h5A5A5A5A, 4'hF);
      step();
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, 1'b0, 1'b1, 32'(i), 32'h0, 4'h0);
         step();
      end
      pulses1 = 0;
      pulses2 = 0;
      apply_reset();
      check("busy again after reset", 32'(busy1 & busy2), 32'h1);
      repeat (DEPTH) step();
      check("lat1 no R_valid across reset", 32'(pulses1), 32'h0);
      check("lat2 no R_valid across reset", 32'(pulses2), 32'h0);
      read_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
